// File: rtl/fetch_unit_if.sv
// Bundle for the fetch unit's two bus faces: the instruction-memory read port
// and the fetch-to-decode handoff.
interface fetch_unit_if #(
   parameter int MEMORY_ADDR_SIZE = 13,
   parameter int INSTR_WIDTH      = 32
);
   logic                        imem_req;
   logic [MEMORY_ADDR_SIZE-1:0] imem_addr;
   logic                        imem_ack;
   logic [INSTR_WIDTH-1:0]      imem_rdata;
   logic                        id_valid;
   logic [INSTR_WIDTH-1:0]      id_instr;
   logic [MEMORY_ADDR_SIZE-1:0] id_pc;
   logic                        id_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output id_valid, id_instr, id_pc,
      input  id_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  id_valid, id_instr, id_pc,
      output id_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests the word at the current PC,
// hands it to decode, and steers the external PC register on accept or branch.
module fetch_unit #(
   parameter int MEMORY_ADDR_SIZE = 13,
   parameter int INSTR_WIDTH      = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [MEMORY_ADDR_SIZE-1:0] pc_addr,
   output logic                        pc_en,
   output logic [MEMORY_ADDR_SIZE-1:0] next_pc,
   input  logic                        branch_taken,
   input  logic [MEMORY_ADDR_SIZE-1:0] branch_target,
   output logic [15:0]                 fetch_count,
   fetch_unit_if.master                bus
);
   localparam logic [MEMORY_ADDR_SIZE-1:0] ADDR_ONE  = {{(MEMORY_ADDR_SIZE-1){1'b0}}, 1'b1};
   localparam logic [MEMORY_ADDR_SIZE-1:0] ADDR_ZERO = {MEMORY_ADDR_SIZE{1'b0}};
   localparam logic [INSTR_WIDTH-1:0]      INSTR_ZERO = {INSTR_WIDTH{1'b0}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PCWAIT = 3'd1,
      FETCH  = 3'd2,
      HOLD   = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   state_t                      state_r, state_s;
   logic                        pc_en_r, pc_en_s;
   logic [MEMORY_ADDR_SIZE-1:0] next_pc_r, next_pc_s;
   logic                        imem_req_r, imem_req_s;
   logic                        id_valid_r, id_valid_s;
   logic [INSTR_WIDTH-1:0]      id_instr_r, id_instr_s;
   logic [MEMORY_ADDR_SIZE-1:0] id_pc_r, id_pc_s;
   logic [15:0]                 fetch_count_r, fetch_count_s;
   logic                        accept_s;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   // Next-state and next-output decode; every output except imem_addr is registered.
   always_comb begin
      state_s       = state_r;
      pc_en_s       = 1'b0;
      next_pc_s     = next_pc_r;
      id_valid_s    = id_valid_r;
      id_instr_s    = id_instr_r;
      id_pc_s       = id_pc_r;
      fetch_count_s = fetch_count_r;
      accept_s      = id_valid_r & bus.id_ready;
      case (state_r)
         IDLE, PCWAIT: begin
            if (branch_taken) begin
               pc_en_s    = 1'b1;
               next_pc_s  = branch_target;
               id_valid_s = 1'b0;
               state_s    = PCWAIT;
            end else begin
               state_s = FETCH;
            end
         end
         FETCH: begin
            if (branch_taken) begin
               // A word returned alongside the branch is wrong-path; only a still-pending one needs draining.
               pc_en_s   = 1'b1;
               next_pc_s = branch_target;
               state_s   = bus.imem_ack ? PCWAIT : DRAIN;
            end else if (bus.imem_ack) begin
               id_instr_s = bus.imem_rdata;
               id_pc_s    = pc_addr;
               id_valid_s = 1'b1;
               state_s    = HOLD;
            end else begin
               state_s = FETCH;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               if (accept_s) begin
                  fetch_count_s = sat_inc(fetch_count_r);
               end else begin
                  fetch_count_s = fetch_count_r;
               end
               pc_en_s    = 1'b1;
               next_pc_s  = branch_target;
               id_valid_s = 1'b0;
               state_s    = PCWAIT;
            end else if (accept_s) begin
               fetch_count_s = sat_inc(fetch_count_r);
               pc_en_s       = 1'b1;
               next_pc_s     = id_pc_r + ADDR_ONE;
               id_valid_s    = 1'b0;
               state_s       = PCWAIT;
            end else begin
               state_s = HOLD;
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               pc_en_s   = 1'b1;
               next_pc_s = branch_target;
            end else begin
               next_pc_s = next_pc_r;
            end
            if (bus.imem_ack) begin
               state_s = PCWAIT;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s    = IDLE;
            id_valid_s = 1'b0;
         end
      endcase
      imem_req_s = (state_s == FETCH);
   end

   // State and registered outputs, cleared asynchronously by rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         pc_en_r       <= 1'b0;
         next_pc_r     <= ADDR_ZERO;
         imem_req_r    <= 1'b0;
         id_valid_r    <= 1'b0;
         id_instr_r    <= INSTR_ZERO;
         id_pc_r       <= ADDR_ZERO;
         fetch_count_r <= 16'd0;
      end else begin
         state_r       <= state_s;
         pc_en_r       <= pc_en_s;
         next_pc_r     <= next_pc_s;
         imem_req_r    <= imem_req_s;
         id_valid_r    <= id_valid_s;
         id_instr_r    <= id_instr_s;
         id_pc_r       <= id_pc_s;
         fetch_count_r <= fetch_count_s;
      end
   end

   assign pc_en         = pc_en_r;
   assign next_pc       = next_pc_r;
   assign fetch_count   = fetch_count_r;
   assign bus.imem_req  = imem_req_r;
   assign bus.imem_addr = pc_addr;
   assign bus.id_valid  = id_valid_r;
   assign bus.id_instr  = id_instr_r;
   assign bus.id_pc     = id_pc_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the PC register, drives memory acks and
// branches by hand, and compares outputs against hand-computed values.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] pc_addr;
   logic        pc_en;
   logic [12:0] next_pc;
   logic        branch_taken;
   logic [12:0] branch_target;
   logic [15:0] fetch_count;
   int          n_checks = 0;
   int          n_fail = 0;
   int          pc_en_cnt = 0;
   int          cnt0;
   bit          stale_seen = 1'b0;

   fetch_unit_if #(.MEMORY_ADDR_SIZE(13), .INSTR_WIDTH(32)) bus ();

   fetch_unit #(.MEMORY_ADDR_SIZE(13), .INSTR_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_addr       (pc_addr),
      .pc_en         (pc_en),
      .next_pc       (next_pc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .fetch_count   (fetch_count),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   // External PC register loaded by the fetch unit.
   always @(posedge clk or negedge rst) begin
      if (!rst) pc_addr <= 13'd0;
      else if (pc_en) pc_addr <= next_pc;
   end

   // Pulse counter and wrong-path word monitor.
   always @(posedge clk) begin
      if (pc_en) pc_en_cnt <= pc_en_cnt + 1;
   end
   always @(negedge clk) begin
      if (bus.id_valid && (bus.id_instr == 32'hDEADBEEF || bus.id_instr == 32'hBADC0DE0))
         stale_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input logic [12:0] addr);
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("imem_req", {31'd0, bus.imem_req}, 32'd1);
      check("imem_addr", {19'd0, bus.imem_addr}, {19'd0, addr});
   endtask

   // Request seen -> ack two edges later -> word held for decode.
   task automatic fetch_one(input logic [12:0] addr, input logic [31:0] data);
      wait_req(addr);
      @(negedge clk);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("id_valid_set", {31'd0, bus.id_valid}, 32'd1);
      check("id_instr", bus.id_instr, data);
      check("id_pc", {19'd0, bus.id_pc}, {19'd0, addr});
      check("req_low_hold", {31'd0, bus.imem_req}, 32'd0);
   endtask

   task automatic accept_check(input logic [12:0] exp_next, input logic [15:0] exp_cnt);
      @(negedge clk);
      check("accept_pc_en", {31'd0, pc_en}, 32'd1);
      check("accept_next_pc", {19'd0, next_pc}, {19'd0, exp_next});
      check("accept_id_valid", {31'd0, bus.id_valid}, 32'd0);
      check("fetch_count", {16'd0, fetch_count}, {16'd0, exp_cnt});
      @(negedge clk);
      check("pc_en_pulse", {31'd0, pc_en}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      branch_taken = 1'b0;
      branch_target = 13'd0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'd0;
      bus.id_ready = 1'b1;
      @(negedge clk);
      check("rst_pc_en", {31'd0, pc_en}, 32'd0);
      check("rst_next_pc", {19'd0, next_pc}, 32'd0);
      check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
      check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
      check("rst_id_instr", bus.id_instr, 32'd0);
      check("rst_id_pc", {19'd0, bus.id_pc}, 32'd0);
      check("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("fetch_after_rst", {31'd0, bus.imem_req}, 32'd1);

      // Sequential fetch of three words.
      cnt0 = pc_en_cnt;
      for (int i = 0; i < 3; i++) begin
         fetch_one(13'(i), 32'hA000_0000 + 32'(i));
         accept_check(13'(i + 1), 16'(i + 1));
      end
      check("seq_pc_en_pulses", 32'(pc_en_cnt - cnt0), 32'd3);

      // Decode stall for five cycles.
      bus.id_ready = 1'b0;
      fetch_one(13'd3, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_id_valid", {31'd0, bus.id_valid}, 32'd1);
         check("stall_id_instr", bus.id_instr, 32'h1234_5678);
         check("stall_pc_en", {31'd0, pc_en}, 32'd0);
         check("stall_imem_req", {31'd0, bus.imem_req}, 32'd0);
      end
      bus.id_ready = 1'b1;
      accept_check(13'd4, 16'd4);

      // Branch with a request outstanding; the late ack must be drained.
      wait_req(13'd4);
      branch_taken = 1'b1;
      branch_target = 13'h100;
      @(negedge clk);
      branch_taken = 1'b0;
      check("drain_pc_en", {31'd0, pc_en}, 32'd1);
      check("drain_next_pc", {19'd0, next_pc}, 32'h100);
      check("drain_req_low", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk);
      check("drain_pc_en_pulse", {31'd0, pc_en}, 32'd0);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("drain_no_valid", {31'd0, bus.id_valid}, 32'd0);
      check("drain_req_pcwait", {31'd0, bus.imem_req}, 32'd0);
      fetch_one(13'h100, 32'h0BAD_F00D);
      accept_check(13'h101, 16'd5);

      // Ack and branch in the same cycle.
      wait_req(13'h101);
      cnt0 = pc_en_cnt;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hBADC0DE0;
      branch_taken = 1'b1;
      branch_target = 13'h040;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      branch_taken = 1'b0;
      check("coinc_no_valid", {31'd0, bus.id_valid}, 32'd0);
      check("coinc_pc_en", {31'd0, pc_en}, 32'd1);
      check("coinc_next_pc", {19'd0, next_pc}, 32'h040);
      @(negedge clk);
      check("coinc_pc_en_pulse", {31'd0, pc_en}, 32'd0);
      check("coinc_pulse_count", 32'(pc_en_cnt - cnt0), 32'd1);
      fetch_one(13'h040, 32'h4040_4040);
      accept_check(13'h041, 16'd6);

      // Branch in HOLD without accept, then wrap from the top address.
      bus.id_ready = 1'b0;
      fetch_one(13'h041, 32'h5555_AAAA);
      branch_taken = 1'b1;
      branch_target = 13'h1FFF;
      @(negedge clk);
      branch_taken = 1'b0;
      check("hold_br_pc_en", {31'd0, pc_en}, 32'd1);
      check("hold_br_next_pc", {19'd0, next_pc}, 32'h1FFF);
      check("hold_br_id_valid", {31'd0, bus.id_valid}, 32'd0);
      check("hold_br_no_count", {16'd0, fetch_count}, 32'd6);
      bus.id_ready = 1'b1;
      fetch_one(13'h1FFF, 32'h7777_0001);
      accept_check(13'h0000, 16'd7);

      // Branch coinciding with accept: counted, but the target wins.
      fetch_one(13'h0000, 32'h0000_C0DE);
      branch_taken = 1'b1;
      branch_target = 13'h020;
      @(negedge clk);
      branch_taken = 1'b0;
      check("br_acc_pc_en", {31'd0, pc_en}, 32'd1);
      check("br_acc_next_pc", {19'd0, next_pc}, 32'h020);
      check("br_acc_count", {16'd0, fetch_count}, 32'd8);
      check("br_acc_id_valid", {31'd0, bus.id_valid}, 32'd0);

      // Asynchronous reset while holding a word, then a stale ack.
      bus.id_ready = 1'b0;
      fetch_one(13'h020, 32'h2020_2020);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_id_valid", {31'd0, bus.id_valid}, 32'd0);
      check("async_id_instr", bus.id_instr, 32'd0);
      check("async_id_pc", {19'd0, bus.id_pc}, 32'd0);
      check("async_next_pc", {19'd0, next_pc}, 32'd0);
      check("async_fetch_count", {16'd0, fetch_count}, 32'd0);
      check("async_imem_req", {31'd0, bus.imem_req}, 32'd0);
      check("async_pc_en", {31'd0, pc_en}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      check("post_rst_no_valid", {31'd0, bus.id_valid}, 32'd0);
      check("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
      bus.id_ready = 1'b1;
      fetch_one(13'h000, 32'h3030_3030);
      accept_check(13'h001, 16'd1);

      check("stale_word_seen", {31'd0, stale_seen}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter MEMORY_ADDR_SIZE, default 13, SHALL set the width of all instruction addresses.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the width of instruction words.
REQ-003 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, asynchronous and active-low (rst=0 resets).
REQ-005 pc_addr  in  MEMORY_ADDR_SIZE  SHALL carry the current PC from the PC register.
REQ-006 pc_en  out  1  SHALL be the PC register load enable.
REQ-007 next_pc  out  MEMORY_ADDR_SIZE  SHALL be the value the PC register loads when pc_en=1.
REQ-008 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  out  MEMORY_ADDR_SIZE  SHALL be the read address, valid while imem_req=1.
REQ-010 imem_ack  in  1  SHALL be a one-cycle pulse marking imem_rdata valid.
REQ-011 imem_rdata  in  INSTR_WIDTH  SHALL be the returned instruction word.
REQ-012 branch_taken  in  1  SHALL be a one-cycle redirect pulse from execute.
REQ-013 branch_target  in  MEMORY_ADDR_SIZE  SHALL be the redirect address, valid with branch_taken.
REQ-014 id_ready  in  1  SHALL indicate that decode accepts id_instr this cycle.
REQ-015 id_valid  out  1  SHALL indicate that id_instr/id_pc hold a valid fetched instruction.
REQ-016 id_instr  out  INSTR_WIDTH  SHALL be the fetched instruction.
REQ-017 id_pc  out  MEMORY_ADDR_SIZE  SHALL be the address id_instr was fetched from.
REQ-018 fetch_count  out  16  SHALL count instructions accepted by decode.

Function
REQ-019 The FSM SHALL have the states IDLE, PCWAIT, FETCH, HOLD and DRAIN; all outputs SHALL be registered except imem_addr.
REQ-020 IDLE: SHALL go to FETCH one cycle after rst deasserts; imem_ack SHALL be ignored.
REQ-021 FETCH: imem_req=1, imem_addr=pc_addr (combinational); on imem_ack SHALL capture id_instr=imem_rdata, id_pc=pc_addr, set id_valid=1 and go to HOLD.
REQ-022 HOLD: imem_req=0; on id_valid&id_ready SHALL clear id_valid, increment fetch_count, pulse pc_en with next_pc=id_pc+1 (mod 2^MEMORY_ADDR_SIZE, so all-ones wraps to 0) and go to PCWAIT.
REQ-023 PCWAIT: SHALL last exactly one cycle with imem_req=0 so that pc_addr settles, then go to FETCH.
REQ-024 pc_en SHALL be high for exactly one cycle per update; next_pc SHALL hold its last value while pc_en=0.
REQ-025 Branch in IDLE, PCWAIT or HOLD: SHALL pulse pc_en with next_pc=branch_target, clear id_valid without counting it, and go to PCWAIT.
REQ-026 Branch in FETCH without imem_ack in the same cycle: SHALL drop imem_req, pulse pc_en with next_pc=branch_target, and go to DRAIN.
REQ-027 Branch in FETCH with imem_ack in the same cycle: SHALL discard imem_rdata (id_valid stays 0), pulse pc_en with next_pc=branch_target, and go to PCWAIT.
REQ-028 DRAIN: imem_req=0; SHALL wait for the stale imem_ack, discard its data and go to PCWAIT.
REQ-029 A branch in DRAIN SHALL update next_pc with a pc_en pulse and remain in DRAIN; the latest target wins.
REQ-030 A branch coinciding with id_valid&id_ready in HOLD SHALL still count the accepted instruction, but next_pc SHALL be branch_target; the branch takes priority over the sequential increment.
REQ-031 fetch_count SHALL saturate at 16'hFFFF.
REQ-032 Throughput SHALL be at most one instruction per (memory latency + 3) cycles; there SHALL be at most one outstanding request.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE, pc_en=0, next_pc=0, imem_req=0, id_valid=0, id_instr=0, id_pc=0 and fetch_count=0, regardless of clock.
REQ-034 Reset asserted mid-request SHALL abandon the request; a later stale imem_ack SHALL be ignored in IDLE.

Verification
REQ-035 Sequential fetch: reset release, pc_addr=0, ack latency 2, id_ready=1 -> id_pc=0,1,2 in order, one pc_en pulse per instruction, fetch_count=3.
REQ-036 Decode stall: id_ready=0 for 5 cycles in HOLD -> id_valid/id_instr stable, no pc_en, no imem_req; id_ready=1 -> next_pc=id_pc+1.
REQ-037 Branch while a request is outstanding: branch_taken with branch_target=0x100 in FETCH, ack arriving 2 cycles later -> ack data discarded, next fetch issued at 0x100, id_valid never high for the stale word.
REQ-038 Simultaneous ack and branch: branch_target=0x040 with imem_ack in the same cycle -> no id_valid, pc_en once with next_pc=0x040.
REQ-039 Wrap: id_pc=0x1FFF accepted -> next_pc=0x0000.
REQ-040 Async reset during HOLD: rst=0 between clock edges -> all outputs 0 at once; pending ack after release ignored; fetch restarts at 0.
